// File: rtl/rand_gen_pkg.sv
// Shared types and constants for the xorshift128 randomness source that feeds
// the 3-share, 32-bit masked AND gadget.
package rand_gen_pkg;

    localparam int K       = 32;
    localparam int NSHARES = 3;

    typedef enum logic [1:0] {
        IDLE,
        WARM,
        RUN
    } state_e;

    typedef struct packed {
        logic [K-1:0] x;
        logic [K-1:0] y;
        logic [K-1:0] z;
        logic [K-1:0] w;
    } xs_state_t;

    // xorshift128 is stuck at zero forever, so an all-zero seed is swapped
    // for Marsaglia's reference state.
    localparam logic [4*K-1:0] DEFAULT_SEED = {32'd123456789, 32'd362436069,
                                               32'd521288629, 32'd88675123};

    function automatic xs_state_t seed_fix(input logic [4*K-1:0] seed);
        return (seed == '0) ? xs_state_t'(DEFAULT_SEED) : xs_state_t'(seed);
    endfunction

endpackage

// File: rtl/xs128_step.sv
// One combinational xorshift128 step: advances {x,y,z,w} and exposes the
// freshly produced word w'.
module xs128_step
    import rand_gen_pkg::*;
(
    input  logic [4*K-1:0] s_cur,
    output logic [4*K-1:0] s_nxt,
    output logic [K-1:0]   w_out
);

    xs_state_t    cur;
    logic [K-1:0] t;
    logic [K-1:0] w_new;

    assign cur   = xs_state_t'(s_cur);
    assign t     = cur.x ^ (cur.x << 11);
    assign w_new = cur.w ^ (cur.w >> 19) ^ t ^ (t >> 8);
    assign w_out = w_new;
    assign s_nxt = {cur.y, cur.z, cur.w, w_new};

endmodule

// File: rtl/rand_gen_n3k32.sv
// Fresh-randomness source for the 3-share, 32-bit masked AND gadget.
// Each beat is three chained xorshift128 words {w1,w2,w3}. After a seed
// handshake the generator discards WARMUP beats, then presents one beat per
// consumer acceptance on o_n / o_rvld.
// Optional build macro RAND_GEN_HEALTH_EN adds o_err and a repetition test
// that stops output when two consecutive registered beats are identical.
module rand_gen_n3k32
    import rand_gen_pkg::*;
#(
    parameter int WARMUP = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 i_seed_vld,
    input  logic [4*K-1:0]       i_seed,
    output logic                 o_seed_rdy,
    input  logic                 i_rrdy,
    output logic                 o_rvld,
    output logic [NSHARES*K-1:0] o_n,
`ifdef RAND_GEN_HEALTH_EN
    output logic                 o_err,
`endif
    output logic                 o_busy
);

    localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
    localparam state_e     AFTER_SEED = (WARMUP == 0) ? RUN : WARM;

    state_e        state_q, state_d;
    xs_state_t     xs_q;
    logic [7:0]    cnt_q;

    logic [4*K-1:0]       s1, s2, s3;
    logic [K-1:0]         w1, w2, w3;
    logic [NSHARES*K-1:0] beat;

    logic seed_load;
    logic warm_step;
    logic beat_load;
    logic err_set;

`ifdef RAND_GEN_HEALTH_EN
    logic have_prev_q;
`endif

    // Three chained steps produce one full beat per cycle.
    xs128_step u_step0 (.s_cur(xs_q), .s_nxt(s1), .w_out(w1));
    xs128_step u_step1 (.s_cur(s1),   .s_nxt(s2), .w_out(w2));
    xs128_step u_step2 (.s_cur(s2),   .s_nxt(s3), .w_out(w3));

    assign beat = {w1, w2, w3};

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state, handshake outputs and datapath load controls.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d    = state_q;
        o_seed_rdy = 1'b1;
        o_busy     = 1'b0;
        seed_load  = 1'b0;
        warm_step  = 1'b0;
        beat_load  = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_seed_vld) begin
                    seed_load = 1'b1;
                    state_d   = AFTER_SEED;
                end
            end
            WARM: begin
                o_seed_rdy = 1'b0;
                o_busy     = 1'b1;
                warm_step  = 1'b1;
                if (cnt_q == WARM_LAST) state_d = RUN;
            end
            RUN: begin
                // A reseed wins over a simultaneous acceptance; the current
                // beat is treated as consumed.
                if (i_seed_vld) begin
                    seed_load = 1'b1;
                    state_d   = AFTER_SEED;
                end else if (!o_rvld || i_rrdy) begin
                    beat_load = 1'b1;
`ifdef RAND_GEN_HEALTH_EN
                    if (have_prev_q && (beat == o_n)) begin
                        beat_load = 1'b0;
                        err_set   = 1'b1;
                        state_d   = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Generator state, warm-up counter and registered output beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the asynchronous reset clears every datapath register so the
        // outputs go quiet the instant rst_ni falls, not at the next edge.
        if (!rst_ni) begin
            xs_q   <= '0;
            cnt_q  <= '0;
            o_n    <= '0;
            o_rvld <= 1'b0;
        end else if (seed_load) begin
            xs_q   <= seed_fix(i_seed);
            cnt_q  <= '0;
            o_rvld <= 1'b0;
        end else if (warm_step) begin
            xs_q  <= s3;
            cnt_q <= cnt_q + 8'd1;
        end else if (beat_load) begin
            xs_q   <= s3;
            o_n    <= beat;
            o_rvld <= 1'b1;
        end else if (err_set) begin
            o_rvld <= 1'b0;
        end
    end

`ifdef RAND_GEN_HEALTH_EN
    // Repetition-test flag and "previous beat present" marker.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            o_err       <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (seed_load) begin
            o_err       <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end else if (beat_load) begin
            have_prev_q <= 1'b1;
        end
    end
`endif

endmodule
